// File: rtl/slink_int_gpio_rx_ctrl_if.sv
// Link-to-app snapshot handshake between the flow-control state machine and the
// interrupt/GPIO consumer. Payload is {gpio, interrupt} with interrupts in the LSBs.
interface slink_int_gpio_rx_ctrl_if #(
  parameter int unsigned NUM_INTS  = 16,
  parameter int unsigned NUM_GPIOS = 8
) ();

  logic                          l2a_valid;
  logic                          l2a_accept;
  logic [NUM_INTS+NUM_GPIOS-1:0] l2a_data;

  modport master (
    output l2a_valid,
    output l2a_data,
    input  l2a_accept
  );

  modport slave (
    input  l2a_valid,
    input  l2a_data,
    output l2a_accept
  );

endinterface

// File: rtl/slink_int_gpio_rx_ctrl.sv
// Consumes {gpio, interrupt} snapshots, tracks sticky/level interrupt status and a masked IRQ.
// Optional stale-link timer enabled by defining SLINK_INT_GPIO_RX_STALE_TIMER_EN.
module slink_int_gpio_rx_ctrl #(
  parameter int unsigned NUM_INTS     = 16,
  parameter int unsigned NUM_GPIOS    = 8,
  parameter int unsigned STALE_CYCLES = 1024
) (
  input  logic                 app_clk,
  input  logic                 app_reset,
  input  logic                 enable,
  slink_int_gpio_rx_ctrl_if.slave l2a,
  input  logic [NUM_INTS-1:0]  swi_int_edge_mode,
  input  logic [NUM_INTS-1:0]  swi_int_mask,
  input  logic [NUM_INTS-1:0]  swi_int_clear,
  output logic [NUM_INTS-1:0]  o_interrupt,
  output logic [NUM_GPIOS-1:0] o_gpio,
  output logic [NUM_INTS-1:0]  int_status,
  output logic                 irq,
  output logic                 gpio_change,
  output logic [15:0]          update_count,
  output logic                 link_stale
);

  typedef enum logic [1:0] {StIdle, StSync, StActive} state_e;

  state_e               state_q, state_d;
  logic [NUM_INTS-1:0]  int_q, int_d;
  logic [NUM_GPIOS-1:0] gpio_q, gpio_d;
  logic [NUM_INTS-1:0]  status_q, status_d;
  logic                 irq_q, irq_d;
  logic                 gchg_q, gchg_d;
  logic [15:0]          count_q, count_d;

  logic                 accept;
  logic                 transfer;
  logic [NUM_INTS-1:0]  new_int;
  logic [NUM_GPIOS-1:0] new_gpio;
  logic [NUM_INTS-1:0]  rise;

  assign accept   = (state_q != StIdle);
  assign transfer = l2a.l2a_valid && accept;
  assign new_int  = l2a.l2a_data[NUM_INTS-1:0];
  assign new_gpio = l2a.l2a_data[NUM_INTS +: NUM_GPIOS];

  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    gpio_d   = gpio_q;
    rise     = '0;
    gchg_d   = 1'b0;
    count_d  = count_q;
    irq_d    = |(status_q & ~swi_int_mask);

    unique case (state_q)
      StIdle:   state_d = StSync;
      StSync:   if (transfer) state_d = StActive;
      StActive: state_d = StActive;
      default:  state_d = StIdle;
    endcase

    if (transfer) begin
      int_d  = new_int;
      gpio_d = new_gpio;
      if (state_q == StActive) begin
        rise    = new_int & ~int_q;
        gchg_d  = (new_gpio != gpio_q);
        count_d = count_q + 16'd1;
      end else begin
        // First snapshot after enable is only a baseline.
        count_d = 16'd1;
      end
    end

    // Edge bits: a new rising edge beats a same-cycle clear. Level bits track post-update level.
    status_d = (swi_int_edge_mode & ((status_q & ~swi_int_clear) | rise))
             | (~swi_int_edge_mode & int_d);

    // Disable wins over everything, but a same-cycle transfer still updates the levels.
    if (!enable) begin
      state_d  = StIdle;
      status_d = '0;
      irq_d    = 1'b0;
      gchg_d   = 1'b0;
      count_d  = '0;
    end
  end

  always_ff @(posedge app_clk or posedge app_reset) begin
    if (app_reset) begin
      state_q  <= StIdle;
      int_q    <= '0;
      gpio_q   <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
      gchg_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      int_q    <= int_d;
      gpio_q   <= gpio_d;
      status_q <= status_d;
      irq_q    <= irq_d;
      gchg_q   <= gchg_d;
      count_q  <= count_d;
    end
  end

`ifdef SLINK_INT_GPIO_RX_STALE_TIMER_EN
  localparam int unsigned StaleW = $clog2(STALE_CYCLES);
  localparam logic [StaleW-1:0] StaleMax = StaleW'(STALE_CYCLES - 1);

  logic [StaleW-1:0] stale_cnt_q, stale_cnt_d;
  logic              stale_q, stale_d;

  always_comb begin
    stale_cnt_d = stale_cnt_q;
    stale_d     = stale_q;
    if (state_q == StActive) begin
      if (transfer) begin
        stale_cnt_d = '0;
        stale_d     = 1'b0;
      end else if (stale_cnt_q == StaleMax) begin
        stale_d = 1'b1;
      end else begin
        stale_cnt_d = stale_cnt_q + 1'b1;
      end
    end
    if (!enable) begin
      stale_cnt_d = '0;
      stale_d     = 1'b0;
    end
  end

  always_ff @(posedge app_clk or posedge app_reset) begin
    if (app_reset) begin
      stale_cnt_q <= '0;
      stale_q     <= 1'b0;
    end else begin
      stale_cnt_q <= stale_cnt_d;
      stale_q     <= stale_d;
    end
  end

  assign link_stale = stale_q;
`else
  assign link_stale = 1'b0;
`endif

  assign l2a.l2a_accept = accept;
  assign o_interrupt    = int_q;
  assign o_gpio         = gpio_q;
  assign int_status     = status_q;
  assign irq            = irq_q;
  assign gpio_change    = gchg_q;
  assign update_count   = count_q;

endmodule

// File: doc/slink_int_gpio_rx_ctrl.md
# slink_int_gpio_rx_ctrl

Application-side consumer for interrupt/GPIO state packets delivered by the generic flow-control state machine's link-to-app (l2a) port. It accepts snapshots of `{gpio, interrupt}`, drives registered GPIO/interrupt outputs, and per interrupt either latches rising edges into sticky status (cleared by write-1-to-clear) or mirrors the level. It also produces a masked aggregate IRQ, counts updates, and optionally flags a stale link.

## Interface
- NUM_INTS, 16, interrupt bits per snapshot (multiple of 8)
- NUM_GPIOS, 8, GPIO bits per snapshot (multiple of 8)
- STALE_CYCLES, 1024, app_clk cycles without an update before `link_stale` asserts (≥2)

- app_clk  in  1  application clock
- app_reset  in  1  reset, asynchronous, active-high
- enable  in  1  block enable, already synchronous to app_clk
- l2a_valid  in  1  snapshot valid from the flow-control SM
- l2a_accept  out  1  consumer ready; a transfer occurs on `l2a_valid && l2a_accept`
- l2a_data  in  NUM_INTS+NUM_GPIOS  snapshot, `{gpio, interrupt}`; interrupts in the LSBs
- swi_int_edge_mode  in  NUM_INTS  1 = rising-edge sticky, 0 = level
- swi_int_mask  in  NUM_INTS  1 = excluded from `irq`
- swi_int_clear  in  NUM_INTS  write-1-to-clear, one-cycle pulse per bit
- o_interrupt  out  NUM_INTS  last received interrupt levels
- o_gpio  out  NUM_GPIOS  last received GPIO levels
- int_status  out  NUM_INTS  sticky/level status
- irq  out  1  registered `|(int_status & ~swi_int_mask)`
- gpio_change  out  1  one-cycle pulse when an accepted snapshot changes any GPIO bit
- update_count  out  16  accepted snapshots while active; wraps 0xFFFF→0x0000
- link_stale  out  1  no update for STALE_CYCLES

## Operation
- FSM states:
  - IDLE: `l2a_accept`=0.
  - SYNC: `l2a_accept`=1. Waits for the first snapshot.
  - ACTIVE: `l2a_accept`=1.
- FSM transitions:
  - IDLE→SYNC when `enable`=1.
  - SYNC→ACTIVE on the first transfer.
  - Any state→IDLE when `enable`=0, which takes priority.
- `l2a_accept` is decoded from the registered state only. A transfer in the same cycle `enable` falls is still taken.
- First transfer (SYNC):
  - Loads `o_interrupt`/`o_gpio` as the baseline.
  - No edges are detected and `gpio_change` stays 0.
  - Level-mode status bits follow the level.
  - `update_count` is set to 1.
- ACTIVE transfer:
  - rise = new_int & ~o_interrupt.
  - Outputs load the new snapshot.
  - `update_count` increments.
  - `gpio_change` pulses if new_gpio ≠ o_gpio.
- Status, per bit i:
  - Edge mode: status ← (status & ~clear) | rise. A set in the same cycle as a clear wins.
  - Level mode: status ← o_interrupt[i] (post-update value). `swi_int_clear` is ignored.
- Changing `swi_int_edge_mode` takes effect on the next cycle. Switching a bit to edge mode keeps its current status value.
- Entering IDLE:
  - Clears `int_status`, `irq`, `gpio_change`, `link_stale` and `update_count`.
  - `o_interrupt`/`o_gpio` hold their last values.
- Reset:
  - State is IDLE.
  - All outputs are 0, including `l2a_accept`, `o_interrupt` and `o_gpio`.

## Timing
- Transfer at edge N:
  - `o_interrupt`, `o_gpio`, `int_status`, `gpio_change` and `update_count` are valid after edge N.
  - `irq` is valid after edge N+1.
- `swi_int_clear` at edge N: status bit low after N; `irq` low after N+1, unless another unmasked bit is set.
- `swi_int_mask` change at edge N: `irq` reflects it after N+1.
- `enable` falling at edge N: state is IDLE and status/counters are cleared after N; `l2a_accept` is low after N.
- `enable` rising: SYNC after the next edge; accepts from the following cycle.
- `l2a_valid` may be held across cycles. Each cycle with valid&&accept is a separate transfer.

## Configuration
- SLINK_INT_GPIO_RX_STALE_TIMER_EN defined:
  - A `$clog2(STALE_CYCLES)`-bit counter runs in ACTIVE only.
  - The counter clears on every transfer.
  - `link_stale` sets when the counter reaches STALE_CYCLES-1 with no transfer. It is sticky until the next transfer or IDLE.
  - The counter saturates.
- Not defined: no counter is instantiated and `link_stale` is tied to 0.

## Test plan
- Reset, enable=1, first snapshot 0x00_0005 → o_interrupt=0x0005, int_status=0x0005 (all level mode), gpio_change=0, update_count=1, irq=1 one cycle later.
- Edge mode 0xFFFF, mask 0; snapshots 0x0000 then 0x0003 → int_status=0x0003, irq=1; snapshot 0x0000 → status stays 0x0003; clear=0x0001 → status=0x0002.
- Edge mode bit 0; a rising edge on bit 0 transfers in the same cycle as swi_int_clear[0]=1 → int_status[0]=1 (set wins).
- Snapshot GPIO 0x00→0xA5 in ACTIVE → o_gpio=0xA5, gpio_change exactly one cycle high; a repeat of 0xA5 → no pulse.
- enable dropped mid-stream with l2a_valid high → that cycle's transfer is taken, then accept=0, status/irq/update_count=0, o_gpio held; re-enable → next snapshot is treated as baseline with no edges.
- (STALE_CYCLES=16, macro defined) no transfers for 16 cycles in ACTIVE → link_stale=1; next transfer → link_stale=0. Without the macro → link_stale stays 0.
